ctrl_decode_stage: RTL and testbench



---
 rtl/ctrl_pkg.sv | 83 ++++++++
 rtl/ctrl_decode_comb.sv | 123 ++++++++++++
 rtl/ctrl_decode_stage.sv | 124 ++++++++++++
 tb/tb_ctrl_decode_stage.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// rtl/ctrl_pkg.sv - opcodes, control encodings and the ID/EX control bundle type
package ctrl_pkg;

    // RV32I major opcodes
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    // func7 values recognised on R-type and immediate shifts
    localparam logic [6:0] F7_BASE    = 7'b0000000;
    localparam logic [6:0] F7_ALT     = 7'b0100000;
    localparam logic [6:0] F7_MULDIV  = 7'b0000001;

    // ALU operation encoding
    localparam logic [3:0] ALU_ADD    = 4'b0000;
    localparam logic [3:0] ALU_SUB    = 4'b0001;
    localparam logic [3:0] ALU_SLL    = 4'b0010;
    localparam logic [3:0] ALU_SLT    = 4'b0011;
    localparam logic [3:0] ALU_SLTU   = 4'b0100;
    localparam logic [3:0] ALU_XOR    = 4'b0101;
    localparam logic [3:0] ALU_SRL    = 4'b0110;
    localparam logic [3:0] ALU_SRA    = 4'b0111;
    localparam logic [3:0] ALU_OR     = 4'b1000;
    localparam logic [3:0] ALU_AND    = 4'b1001;
    localparam logic [3:0] ALU_PASS_B = 4'b1010;

    // Operand selects
    localparam logic       OPA_RS1    = 1'b0;
    localparam logic       OPA_PC     = 1'b1;
    localparam logic [1:0] OPB_RS2    = 2'b00;
    localparam logic [1:0] OPB_IMM    = 2'b01;

    // Write-back source select
    localparam logic [1:0] WB_ALU     = 2'b00;
    localparam logic [1:0] WB_MEM     = 2'b01;
    localparam logic [1:0] WB_PC4     = 2'b10;
    localparam logic [1:0] WB_MD      = 2'b11;

    // Unconditional branch kind
    localparam logic [1:0] UNCBR_NONE = 2'b00;
    localparam logic [1:0] UNCBR_JAL  = 2'b10;
    localparam logic [1:0] UNCBR_JALR = 2'b11;

    typedef struct packed {
        logic       op_a_sel;
        logic [1:0] op_b_sel;
        logic [3:0] alu_ctrl;
        logic [2:0] md_op;
        logic       is_md;
        logic       is_br;
        logic [2:0] br_type;
        logic [1:0] is_uncbr;
        logic       mem_wren;
        logic       mem_rden;
        logic [2:0] mem_size;
        logic       rd_wren;
        logic [1:0] wb_sel;
        logic       illegal;
    } ctrl_bundle_t;

    // Shared func3 -> ALU map for R-type and OP-IMM (base func7 variants)
    function automatic logic [3:0] alu_from_f3(input logic [2:0] f3);
        logic [3:0] op;
        case (f3)
            3'b000:  op = ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/ctrl_decode_comb.sv
// rtl/ctrl_decode_comb.sv - pure combinational RV32I(+M) instruction to control bundle decode
module ctrl_decode_comb
    import ctrl_pkg::*;
#(
    parameter bit EN_M = 1'b1
) (
    input  logic [31:0]  instr_i,
    output ctrl_bundle_t bundle_o
);

    logic [6:0] opcode;
    logic [2:0] f3;
    logic [6:0] f7;
    logic       rd_nz;
    logic       unused_bits;

    assign opcode      = instr_i[6:0];
    assign f3          = instr_i[14:12];
    assign f7          = instr_i[31:25];
    assign rd_nz       = (instr_i[11:7] != 5'd0);
    // Register indices are resolved elsewhere in the pipeline
    assign unused_bits = ^instr_i[24:15];

    ctrl_bundle_t dec;
    logic         ill;

    // Decode by opcode, then collapse any illegal encoding into an inert bundle
    always_comb begin
        dec = '0;
        ill = 1'b0;
        case (opcode)
            OPC_OP: begin
                dec.op_b_sel = OPB_RS2;
                dec.rd_wren  = rd_nz;
                dec.wb_sel   = WB_ALU;
                if (f7 == F7_BASE) begin
                    dec.alu_ctrl = alu_from_f3(f3);
                end else if (f7 == F7_ALT) begin
                    if (f3 == 3'b000)      dec.alu_ctrl = ALU_SUB;
                    else if (f3 == 3'b101) dec.alu_ctrl = ALU_SRA;
                    else                   ill = 1'b1;
                end else if (EN_M && (f7 == F7_MULDIV)) begin
                    dec.is_md  = 1'b1;
                    dec.md_op  = f3;
                    dec.wb_sel = WB_MD;
                end else begin
                    ill = 1'b1;
                end
            end
            OPC_OPIMM: begin
                dec.op_b_sel = OPB_IMM;
                dec.rd_wren  = rd_nz;
                dec.alu_ctrl = alu_from_f3(f3);
                // Shift immediates carry the shift kind in imm[11:5]
                if (f3 == 3'b001) begin
                    if (f7 != F7_BASE) ill = 1'b1;
                end else if (f3 == 3'b101) begin
                    if (f7 == F7_ALT)       dec.alu_ctrl = ALU_SRA;
                    else if (f7 != F7_BASE) ill = 1'b1;
                end
            end
            OPC_LOAD: begin
                dec.op_b_sel = OPB_IMM;
                dec.alu_ctrl = ALU_ADD;
                dec.mem_rden = 1'b1;
                dec.mem_size = f3;
                dec.rd_wren  = rd_nz;
                dec.wb_sel   = WB_MEM;
                if (!(f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101})) ill = 1'b1;
            end
            OPC_STORE: begin
                dec.op_b_sel = OPB_IMM;
                dec.alu_ctrl = ALU_ADD;
                dec.mem_wren = 1'b1;
                dec.mem_size = f3;
                if (f3 > 3'b010) ill = 1'b1;
            end
            OPC_BRANCH: begin
                dec.op_b_sel = OPB_RS2;
                dec.alu_ctrl = ALU_SUB;
                dec.is_br    = 1'b1;
                dec.br_type  = f3;
                if ((f3 == 3'b010) || (f3 == 3'b011)) ill = 1'b1;
            end
            OPC_JAL: begin
                dec.op_a_sel = OPA_PC;
                dec.op_b_sel = OPB_IMM;
                dec.alu_ctrl = ALU_ADD;
                dec.is_uncbr = UNCBR_JAL;
                dec.rd_wren  = rd_nz;
                dec.wb_sel   = WB_PC4;
            end
            OPC_JALR: begin
                dec.op_a_sel = OPA_RS1;
                dec.op_b_sel = OPB_IMM;
                dec.alu_ctrl = ALU_ADD;
                dec.is_uncbr = UNCBR_JALR;
                dec.rd_wren  = rd_nz;
                dec.wb_sel   = WB_PC4;
                if (f3 != 3'b000) ill = 1'b1;
            end
            OPC_LUI: begin
                dec.op_b_sel = OPB_IMM;
                dec.alu_ctrl = ALU_PASS_B;
                dec.rd_wren  = rd_nz;
            end
            OPC_AUIPC: begin
                dec.op_a_sel = OPA_PC;
                dec.op_b_sel = OPB_IMM;
                dec.alu_ctrl = ALU_ADD;
                dec.rd_wren  = rd_nz;
            end
            default: ill = 1'b1;
        endcase
        if (ill) begin
            dec         = '0;
            dec.illegal = 1'b1;
        end
    end

    assign bundle_o = dec;

endmodule

// File: rtl/ctrl_decode_stage.sv
// rtl/ctrl_decode_stage.sv - registered ID stage: decode, M-op latency hold and valid/ready output
module ctrl_decode_stage
    import ctrl_pkg::*;
#(
    parameter bit          EN_M    = 1'b1,
    parameter int unsigned MUL_LAT = 1,
    parameter int unsigned DIV_LAT = 32
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        flush_i,
    input  logic [31:0] instr_i,
    input  logic        in_valid_i,
    output logic        in_ready_o,
    output logic        out_valid_o,
    input  logic        out_ready_i,
    output logic        op_a_sel_o,
    output logic [1:0]  op_b_sel_o,
    output logic [3:0]  alu_ctrl_o,
    output logic [2:0]  md_op_o,
    output logic        is_md_o,
    output logic        is_br_o,
    output logic [2:0]  br_type_o,
    output logic [1:0]  is_uncbr_o,
    output logic        mem_wren_o,
    output logic        mem_rden_o,
    output logic [2:0]  mem_size_o,
    output logic        rd_wren_o,
    output logic [1:0]  wb_sel_o,
    output logic        illegal_o
);

    localparam int            CW      = $clog2(DIV_LAT + 1);
    localparam logic [CW-1:0] MUL_CNT = CW'(MUL_LAT - 1);
    localparam logic [CW-1:0] DIV_CNT = CW'(DIV_LAT - 1);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_HOLD  = 2'b01,
        ST_FULL  = 2'b10
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    ctrl_bundle_t  bundle_q, bundle_d;
    ctrl_bundle_t  dec_bundle;
    logic          accept;
    logic [CW-1:0] cnt_ld;

    ctrl_decode_comb #(
        .EN_M (EN_M)
    ) u_decode (
        .instr_i  (instr_i),
        .bundle_o (dec_bundle)
    );

    // Reset and flush block acceptance so nothing enters in those cycles
    assign in_ready_o = !rst_i && !flush_i &&
                        ((state_q == ST_EMPTY) || ((state_q == ST_FULL) && out_ready_i));
    assign accept     = in_valid_i && in_ready_o;
    assign cnt_ld     = dec_bundle.md_op[2] ? DIV_CNT : MUL_CNT;

    // Next state, latency counter and bundle capture
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        bundle_d = bundle_q;
        if (flush_i) begin
            state_d  = ST_EMPTY;
            cnt_d    = '0;
            bundle_d = '0;
        end else if (accept) begin
            bundle_d = dec_bundle;
            if (dec_bundle.is_md && (cnt_ld != '0)) begin
                state_d = ST_HOLD;
                cnt_d   = cnt_ld;
            end else begin
                state_d = ST_FULL;
                cnt_d   = '0;
            end
        end else begin
            case (state_q)
                ST_HOLD: begin
                    cnt_d = cnt_q - 1'b1;
                    if (cnt_q == CW'(1)) state_d = ST_FULL;
                end
                ST_FULL: begin
                    if (out_ready_i) state_d = ST_EMPTY;
                end
                default: state_d = ST_EMPTY;
            endcase
        end
    end

    // State, counter and bundle registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= ST_EMPTY;
            cnt_q    <= '0;
            bundle_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            bundle_q <= bundle_d;
        end
    end

    assign out_valid_o = (state_q == ST_FULL);
    assign op_a_sel_o  = bundle_q.op_a_sel;
    assign op_b_sel_o  = bundle_q.op_b_sel;
    assign alu_ctrl_o  = bundle_q.alu_ctrl;
    assign md_op_o     = bundle_q.md_op;
    assign is_md_o     = bundle_q.is_md;
    assign is_br_o     = bundle_q.is_br;
    assign br_type_o   = bundle_q.br_type;
    assign is_uncbr_o  = bundle_q.is_uncbr;
    assign mem_wren_o  = bundle_q.mem_wren;
    assign mem_rden_o  = bundle_q.mem_rden;
    assign mem_size_o  = bundle_q.mem_size;
    assign rd_wren_o   = bundle_q.rd_wren;
    assign wb_sel_o    = bundle_q.wb_sel;
    assign illegal_o   = bundle_q.illegal;

endmodule

// File: tb/tb_ctrl_decode_stage.sv
// tb/tb_ctrl_decode_stage.sv - scoreboard bench for the registered decode stage
module tb_ctrl_decode_stage;

    logic        clk = 1'b0;
    logic        rst_i, flush_i, in_valid_i, out_ready_i;
    logic [31:0] instr_i;
    logic        in_ready_o, out_valid_o, op_a_sel_o, is_md_o, is_br_o;
    logic        mem_wren_o, mem_rden_o, rd_wren_o, illegal_o;
    logic [1:0]  op_b_sel_o, is_uncbr_o, wb_sel_o;
    logic [3:0]  alu_ctrl_o;
    logic [2:0]  md_op_o, br_type_o, mem_size_o;

    logic        nm_in_ready, nm_valid, nm_op_a, nm_is_md, nm_is_br;
    logic        nm_wren, nm_rden, nm_rd_wren, nm_illegal;
    logic [1:0]  nm_op_b, nm_uncbr, nm_wb;
    logic [3:0]  nm_alu;
    logic [2:0]  nm_md_op, nm_br_type, nm_size;

    always #5 clk = ~clk;

    ctrl_decode_stage #(.EN_M(1'b1), .MUL_LAT(1), .DIV_LAT(32)) dut (
        .clk_i(clk), .rst_i(rst_i), .flush_i(flush_i), .instr_i(instr_i),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .out_valid_o(out_valid_o),
        .out_ready_i(out_ready_i), .op_a_sel_o(op_a_sel_o), .op_b_sel_o(op_b_sel_o),
        .alu_ctrl_o(alu_ctrl_o), .md_op_o(md_op_o), .is_md_o(is_md_o), .is_br_o(is_br_o),
        .br_type_o(br_type_o), .is_uncbr_o(is_uncbr_o), .mem_wren_o(mem_wren_o),
        .mem_rden_o(mem_rden_o), .mem_size_o(mem_size_o), .rd_wren_o(rd_wren_o),
        .wb_sel_o(wb_sel_o), .illegal_o(illegal_o)
    );

    ctrl_decode_stage #(.EN_M(1'b0), .MUL_LAT(1), .DIV_LAT(32)) dut_nm (
        .clk_i(clk), .rst_i(rst_i), .flush_i(flush_i), .instr_i(instr_i),
        .in_valid_i(in_valid_i), .in_ready_o(nm_in_ready), .out_valid_o(nm_valid),
        .out_ready_i(out_ready_i), .op_a_sel_o(nm_op_a), .op_b_sel_o(nm_op_b),
        .alu_ctrl_o(nm_alu), .md_op_o(nm_md_op), .is_md_o(nm_is_md), .is_br_o(nm_is_br),
        .br_type_o(nm_br_type), .is_uncbr_o(nm_uncbr), .mem_wren_o(nm_wren),
        .mem_rden_o(nm_rden), .mem_size_o(nm_size), .rd_wren_o(nm_rd_wren),
        .wb_sel_o(nm_wb), .illegal_o(nm_illegal)
    );

    logic [25:0] act_v;
    assign act_v = {op_a_sel_o, op_b_sel_o, alu_ctrl_o, md_op_o, is_md_o, is_br_o, br_type_o,
                    is_uncbr_o, mem_wren_o, mem_rden_o, mem_size_o, rd_wren_o, wb_sel_o, illegal_o};

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    logic [25:0] exp_q[$];
    logic [25:0] mask_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [25:0] vec(
        input logic a, input logic [1:0] b, input logic [3:0] alu, input logic [2:0] md,
        input logic ismd, input logic isbr, input logic [2:0] bt, input logic [1:0] unc,
        input logic wr, input logic rd, input logic [2:0] sz, input logic rdw,
        input logic [1:0] wb, input logic ill);
        return {a, b, alu, md, ismd, isbr, bt, unc, wr, rd, sz, rdw, wb, ill};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, req);
        end
    endtask

    // Monitor: every consumed bundle must match the oldest expected entry
    always @(negedge clk) begin
        if (!rst_i && out_valid_o && out_ready_i) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_out", {6'b0, act_v}, 32'hFFFF_FFFF);
            end else begin
                logic [25:0] e, m;
                e = exp_q.pop_front();
                m = mask_q.pop_front();
                chk("bundle", {6'b0, act_v & m}, {6'b0, e & m});
            end
        end
    end

    task automatic send(input logic [31:0] ins, input bit push,
                        input logic [25:0] e, input logic [25:0] m);
        int n;
        if (push) begin
            exp_q.push_back(e);
            mask_q.push_back(m);
        end
        instr_i    = ins;
        in_valid_i = 1'b1;
        n = 0;
        @(negedge clk);
        while (!in_ready_o && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) chk("accept_timeout", 32'(n), 32'd0);
        @(posedge clk);
        #1;
        in_valid_i = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(posedge clk);
            n++;
        end
        chk("drain", 32'(exp_q.size()), 32'd0);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [25:0] M_CORE, M_OPA, M_OPB, M_ALU, M_MD, M_BR, M_SZ, M_WB, M_STD;
        logic [25:0] E_ADD, E_SUB, E_ADD0, E_SRAI, E_LW, E_SW, E_BEQ, E_JAL, E_LUI;
        logic [25:0] E_MUL, E_DIV, E_ILL;
        int t0, n;
        bit saw_ready;

        M_CORE = vec(1'b0, 2'b00, 4'h0, 3'b000, 1'b1, 1'b1, 3'b000, 2'b11, 1'b1, 1'b1, 3'b000, 1'b1, 2'b00, 1'b1);
        M_OPA  = vec(1'b1, 2'b00, 4'h0, 3'b000, 1'b0, 1'b0, 3'b000, 2'b00, 1'b0, 1'b0, 3'b000, 1'b0, 2'b00, 1'b0);
        M_OPB  = vec(1'b0, 2'b11, 4'h0, 3'b000, 1'b0, 1'b0, 3'b000, 2'b00, 1'b0, 1'b0, 3'b000, 1'b0, 2'b00, 1'b0);
        M_ALU  = vec(1'b0, 2'b00, 4'hF, 3'b000, 1'b0, 1'b0, 3'b000, 2'b00, 1'b0, 1'b0, 3'b000, 1'b0, 2'b00, 1'b0);
        M_MD   = vec(1'b0, 2'b00, 4'h0, 3'b111, 1'b0, 1'b0, 3'b000, 2'b00, 1'b0, 1'b0, 3'b000, 1'b0, 2'b00, 1'b0);
        M_BR   = vec(1'b0, 2'b00, 4'h0, 3'b000, 1'b0, 1'b0, 3'b111, 2'b00, 1'b0, 1'b0, 3'b000, 1'b0, 2'b00, 1'b0);
        M_SZ   = vec(1'b0, 2'b00, 4'h0, 3'b000, 1'b0, 1'b0, 3'b000, 2'b00, 1'b0, 1'b0, 3'b111, 1'b0, 2'b00, 1'b0);
        M_WB   = vec(1'b0, 2'b00, 4'h0, 3'b000, 1'b0, 1'b0, 3'b000, 2'b00, 1'b0, 1'b0, 3'b000, 1'b0, 2'b11, 1'b0);
        M_STD  = M_CORE | M_OPA | M_OPB | M_ALU | M_WB;

        E_ADD  = vec(1'b0, 2'b00, 4'b0000, 3'b000, 1'b0, 1'b0, 3'b000, 2'b00, 1'b0, 1'b0, 3'b000, 1'b1, 2'b00, 1'b0);
        E_SUB  = vec(1'b0, 2'b00, 4'b0001, 3'b000, 1'b0, 1'b0, 3'b000, 2'b00, 1'b0, 1'b0, 3'b000, 1'b1, 2'b00, 1'b0);
        E_ADD0 = vec(1'b0, 2'b00, 4'b0000, 3'b000, 1'b0, 1'b0, 3'b000, 2'b00, 1'b0, 1'b0, 3'b000, 1'b0, 2'b00, 1'b0);
        E_SRAI = vec(1'b0, 2'b01, 4'b0111, 3'b000, 1'b0, 1'b0, 3'b000, 2'b00, 1'b0, 1'b0, 3'b000, 1'b1, 2'b00, 1'b0);
        E_LW   = vec(1'b0, 2'b01, 4'b0000, 3'b000, 1'b0, 1'b0, 3'b000, 2'b00, 1'b0, 1'b1, 3'b010, 1'b1, 2'b01, 1'b0);
        E_SW   = vec(1'b0, 2'b01, 4'b0000, 3'b000, 1'b0, 1'b0, 3'b000, 2'b00, 1'b1, 1'b0, 3'b010, 1'b0, 2'b00, 1'b0);
        E_BEQ  = vec(1'b0, 2'b00, 4'b0001, 3'b000, 1'b0, 1'b1, 3'b000, 2'b00, 1'b0, 1'b0, 3'b000, 1'b0, 2'b00, 1'b0);
        E_JAL  = vec(1'b1, 2'b01, 4'b0000, 3'b000, 1'b0, 1'b0, 3'b000, 2'b10, 1'b0, 1'b0, 3'b000, 1'b1, 2'b10, 1'b0);
        E_LUI  = vec(1'b0, 2'b01, 4'b1010, 3'b000, 1'b0, 1'b0, 3'b000, 2'b00, 1'b0, 1'b0, 3'b000, 1'b1, 2'b00, 1'b0);
        E_MUL  = vec(1'b0, 2'b00, 4'b0000, 3'b000, 1'b1, 1'b0, 3'b000, 2'b00, 1'b0, 1'b0, 3'b000, 1'b1, 2'b11, 1'b0);
        E_DIV  = vec(1'b0, 2'b00, 4'b0000, 3'b100, 1'b1, 1'b0, 3'b000, 2'b00, 1'b0, 1'b0, 3'b000, 1'b1, 2'b11, 1'b0);
        E_ILL  = vec(1'b0, 2'b00, 4'b0000, 3'b000, 1'b0, 1'b0, 3'b000, 2'b00, 1'b0, 1'b0, 3'b000, 1'b0, 2'b00, 1'b1);

        rst_i = 1'b1; flush_i = 1'b0; in_valid_i = 1'b0; out_ready_i = 1'b1; instr_i = 32'h0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", {31'b0, in_ready_o}, 32'd0);
        chk("rst_out_valid", {31'b0, out_valid_o}, 32'd0);
        chk("rst_bundle", {6'b0, act_v}, 32'd0);
        @(posedge clk); #1;
        rst_i = 1'b0;
        @(negedge clk);
        chk("post_rst_in_ready", {31'b0, in_ready_o}, 32'd1);
        chk("post_rst_out_valid", {31'b0, out_valid_o}, 32'd0);
        @(posedge clk); #1;

        // Back-to-back non-M stream, one per cycle
        t0 = cyc;
        send(32'h003100B3, 1'b1, E_ADD,  M_STD);
        send(32'h403100B3, 1'b1, E_SUB,  M_STD);
        send(32'h00310033, 1'b1, E_ADD0, M_STD);
        send(32'h40315093, 1'b1, E_SRAI, M_STD);
        send(32'h00812283, 1'b1, E_LW,   M_STD | M_SZ);
        send(32'h00512423, 1'b1, E_SW,   M_CORE | M_OPA | M_OPB | M_ALU | M_SZ);
        send(32'h00208463, 1'b1, E_BEQ,  M_CORE | M_OPA | M_OPB | M_ALU | M_BR);
        send(32'h008000EF, 1'b1, E_JAL,  M_STD);
        send(32'h123450B7, 1'b1, E_LUI,  M_CORE | M_OPB | M_ALU | M_WB);
        send(32'h023100B3, 1'b1, E_MUL,  M_CORE | M_MD | M_WB);
        send(32'h0000007F, 1'b1, E_ILL,  M_CORE);
        send(32'h40311093, 1'b1, E_ILL,  M_CORE);
        chk("throughput_cycles", 32'(cyc - t0), 32'd12);

        // DIV holds for DIV_LAT-1 cycles; the no-M instance flags it illegal
        send(32'h023140B3, 1'b1, E_DIV, M_CORE | M_MD | M_WB);
        @(negedge clk);
        chk("nm_div_valid_illegal", {30'b0, nm_valid, nm_illegal}, 32'd3);
        chk("nm_div_enables", {28'b0, nm_rd_wren, nm_is_md, nm_rden, nm_wren}, 32'd0);
        n = 0; saw_ready = 1'b0;
        while (!out_valid_o && n < 100) begin
            if (in_ready_o) saw_ready = 1'b1;
            n++;
            @(negedge clk);
        end
        chk("div_hold_cycles", 32'(n), 32'd31);
        chk("div_hold_in_ready", {31'b0, saw_ready}, 32'd0);
        drain();

        // Stall: bundle stays put, nothing else accepted, then flush empties it
        out_ready_i = 1'b0;
        send(32'h403100B3, 1'b0, E_SUB, M_STD);
        instr_i = 32'h00812283; in_valid_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_hs", {30'b0, out_valid_o, in_ready_o}, 32'd2);
            chk("stall_bundle", {6'b0, act_v & M_STD}, {6'b0, E_SUB & M_STD});
        end
        @(posedge clk); #1;
        flush_i = 1'b1;
        @(negedge clk);
        chk("flush_in_ready", {31'b0, in_ready_o}, 32'd0);
        @(posedge clk); #1;
        flush_i = 1'b0; in_valid_i = 1'b0;
        @(negedge clk);
        chk("flush_out_valid", {31'b0, out_valid_o}, 32'd0);
        out_ready_i = 1'b1;
        @(posedge clk); #1;

        // Flush during DIV hold at cnt=10, then reset during another DIV hold
        for (int k = 0; k < 2; k++) begin
            send(32'h023140B3, 1'b0, E_DIV, M_CORE);
            repeat (21) @(posedge clk);
            #1;
            if (k == 0) flush_i = 1'b1;
            else        rst_i   = 1'b1;
            @(posedge clk); #1;
            flush_i = 1'b0; rst_i = 1'b0;
            @(negedge clk);
            chk(k == 0 ? "hold_flush_state" : "hold_rst_state",
                {30'b0, out_valid_o, in_ready_o}, 32'd1);
            n = 0;
            repeat (15) begin
                @(negedge clk);
                if (out_valid_o) n++;
            end
            chk(k == 0 ? "hold_flush_no_out" : "hold_rst_no_out", 32'(n), 32'd0);
            @(posedge clk); #1;
            send(32'h003100B3, 1'b1, E_ADD, M_STD);
            drain();
        end

        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
